// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and datamemory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dm_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [3:0]  m0_byteen;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_pc;
  logic        m0_lock;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_byteen;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_pc;
  logic        m1_lock;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [31:0] DMAdr;
  logic [31:0] DMDataW;
  logic [31:0] DMcurPC;
  logic [3:0]  DMByteEN;
  logic        DMcurWE;
  logic [31:0] DMDataR;

  modport slave (
    input  m0_req, m0_we, m0_byteen, m0_addr, m0_wdata, m0_pc, m0_lock,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_byteen, m1_addr, m1_wdata, m1_pc, m1_lock,
    output m1_ack, m1_rdata,
    output DMAdr, DMDataW, DMcurPC, DMByteEN, DMcurWE,
    input  DMDataR
  );

  modport master (
    output m0_req, m0_we, m0_byteen, m0_addr, m0_wdata, m0_pc, m0_lock,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_byteen, m1_addr, m1_wdata, m1_pc, m1_lock,
    input  m1_ack, m1_rdata,
    input  DMAdr, DMDataW, DMcurPC, DMByteEN, DMcurWE,
    output DMDataR
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of the single datamemory port.
// Define DM_ARB_LOCK_EN to let an owner keep the grant for up to LOCK_MAX transfers.
module dm_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;

  logic [1:0]  req;
  logic [1:0]  we;
  logic [3:0]  byteen [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] pc     [2];

  logic        owner;
  logic        served;
  logic        lock_hold;

  logic [31:0] dm_adr, dm_dataw, dm_pc;
  logic [3:0]  dm_byteen;
  logic        dm_we;

  assign req       = {bus.m1_req, bus.m0_req};
  assign we        = {bus.m1_we,  bus.m0_we};
  assign byteen[0] = bus.m0_byteen;
  assign byteen[1] = bus.m1_byteen;
  assign addr[0]   = bus.m0_addr;
  assign addr[1]   = bus.m1_addr;
  assign wdata[0]  = bus.m0_wdata;
  assign wdata[1]  = bus.m1_wdata;
  assign pc[0]     = bus.m0_pc;
  assign pc[1]     = bus.m1_pc;

  // A transfer happens only when the current owner still holds its request.
  assign owner  = (state_q == GNT1);
  assign served = (state_q != IDLE) && req[owner];

  function automatic state_t arbitrate(input logic [1:0] r, input logic l);
    state_t s;
    s = IDLE;
    if (r == 2'b11)
      s = l ? GNT0 : GNT1;
    else if (r[0])
      s = GNT0;
    else if (r[1])
      s = GNT1;
    return s;
  endfunction

`ifdef DM_ARB_LOCK_EN
  logic [1:0] lock;
  logic [3:0] lock_cnt_q, lock_cnt_d;

  assign lock       = {bus.m1_lock, bus.m0_lock};
  assign lock_hold  = served && lock[owner] && (lock_cnt_q < 4'(LOCK_MAX - 1));
  assign lock_cnt_d = lock_hold ? lock_cnt_q + 4'd1 : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lock_cnt_q <= 4'd0;
    else
      lock_cnt_q <= lock_cnt_d;
  end
`else
  logic unused_lock;
  assign unused_lock = ^{bus.m0_lock, bus.m1_lock, LOCK_MAX[0]};
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: state_d = arbitrate(req, last_q);
      GNT0, GNT1: begin
        if (served)
          last_d = owner;
        // The just-served master counts as "last" for the tie-break.
        if (lock_hold)
          state_d = state_q;
        else
          state_d = arbitrate(req, served ? owner : last_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    dm_adr    = 32'd0;
    dm_dataw  = 32'd0;
    dm_pc     = 32'd0;
    dm_byteen = 4'd0;
    dm_we     = 1'b0;
    if (served) begin
      dm_adr    = addr[owner];
      dm_dataw  = wdata[owner];
      dm_pc     = pc[owner];
      dm_byteen = byteen[owner];
      dm_we     = we[owner];
    end
  end

  assign bus.DMAdr    = dm_adr;
  assign bus.DMDataW  = dm_dataw;
  assign bus.DMcurPC  = dm_pc;
  assign bus.DMByteEN = dm_byteen;
  assign bus.DMcurWE  = dm_we;

  assign bus.m0_ack   = served & ~owner;
  assign bus.m1_ack   = served &  owner;
  assign bus.m0_rdata = (state_q != IDLE) ? bus.DMDataR : 32'd0;
  assign bus.m1_rdata = (state_q != IDLE) ? bus.DMDataR : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: datamemory stand-in, transaction-level reference model,
// directed scenarios followed by random two-master traffic.
module tb_dm_arbiter;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if bus ();
  dm_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

  // datamemory stand-in: combinational read, byte-enabled synchronous write
  logic [31:0] mem [0:255];
  assign bus.DMDataR = mem[bus.DMAdr[9:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (bus.DMcurWE) begin
      for (int b = 0; b < 4; b++)
        if (bus.DMByteEN[b]) mem[bus.DMAdr[9:2]][8*b +: 8] <= bus.DMDataW[8*b +: 8];
    end
  end

  // master-side pending transactions
  bit          act    [2];
  bit          m_we   [2];
  bit          m_lock [2];
  logic [3:0]  m_be   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_pc   [2];
  int          waitc  [2];

  // reference model state
  int          owner;
  bit          last;
  int          lcnt;
  logic [31:0] ref_mem [0:255];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input bit l);
    if (r0 && r1) return l ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic drive();
    bus.m0_req = act[0];    bus.m1_req = act[1];
    bus.m0_we = m_we[0];    bus.m1_we = m_we[1];
    bus.m0_byteen = m_be[0]; bus.m1_byteen = m_be[1];
    bus.m0_addr = m_addr[0]; bus.m1_addr = m_addr[1];
    bus.m0_wdata = m_wd[0]; bus.m1_wdata = m_wd[1];
    bus.m0_pc = m_pc[0];    bus.m1_pc = m_pc[1];
    bus.m0_lock = m_lock[0]; bus.m1_lock = m_lock[1];
  endtask

  task automatic set_txn(input int m, input bit w, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d, input bit lk);
    act[m] = 1'b1; m_we[m] = w; m_be[m] = be; m_addr[m] = a;
    m_wd[m] = d; m_pc[m] = 32'h0040_0000 + $urandom_range(0, 255) * 4; m_lock[m] = lk;
    waitc[m] = 0;
  endtask

  task automatic rand_txn(input int m);
    bit w;
    w = 1'($urandom_range(0, 1));
    set_txn(m, w, w ? 4'($urandom_range(1, 15)) : 4'($urandom),
            32'($urandom_range(0, 15)) << 2, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin act[m] = 1'b0; m_lock[m] = 1'b0; end
    drive();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    owner = -1; last = 1'b1; lcnt = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, retire the served transfer.
  task automatic cycle(output int served);
    int nxt;
    bit stay;
    int idx;
    logic [31:0] rd;
    drive();
    @(negedge clk);
    served = (owner >= 0 && act[owner]) ? owner : -1;
    chk("m0_ack", 32'(bus.m0_ack), 32'(served == 0));
    chk("m1_ack", 32'(bus.m1_ack), 32'(served == 1));
    chk("we", 32'(bus.DMcurWE), 32'(served >= 0 && m_we[served]));
    if (served >= 0) begin
      idx = int'(m_addr[served][9:2]);
      chk("addr", bus.DMAdr, m_addr[served]);
      chk("pc", bus.DMcurPC, m_pc[served]);
      chk("byteen", 32'(bus.DMByteEN), 32'(m_be[served]));
      if (m_we[served]) begin
        chk("wdata", bus.DMDataW, m_wd[served]);
        for (int b = 0; b < 4; b++)
          if (m_be[served][b]) ref_mem[idx][8*b +: 8] = m_wd[served][8*b +: 8];
      end else begin
        rd = (served == 0) ? bus.m0_rdata : bus.m1_rdata;
        chk("rdata", rd, ref_mem[idx]);
      end
`ifndef DM_ARB_LOCK_EN
      chk("max_wait", 32'(waitc[served] <= 2), 32'd1);
`endif
      $display("[%0t] m%0d %s addr=%h data=%h", $time, served, m_we[served] ? "WR" : "RD",
               m_addr[served], m_we[served] ? m_wd[served] : ref_mem[idx]);
    end else if (owner < 0) begin
      chk("idle_adr", bus.DMAdr, 32'd0);
      chk("idle_dataw", bus.DMDataW, 32'd0);
      chk("idle_pc", bus.DMcurPC, 32'd0);
      chk("idle_be", 32'(bus.DMByteEN), 32'd0);
    end
    for (int m = 0; m < 2; m++) if (act[m] && served != m) waitc[m]++;
    stay = 1'b0;
`ifdef DM_ARB_LOCK_EN
    if (owner >= 0) begin
      if (served >= 0 && m_lock[served] && lcnt < LOCK_MAX - 1) begin
        stay = 1'b1;
        lcnt++;
      end else begin
        lcnt = 0;
      end
    end
`endif
    if (served >= 0) last = served[0];
    nxt = stay ? owner : pick(act[0], act[1], last);
    @(posedge clk);
    owner = nxt;
    #1;
    if (served >= 0) begin
      act[served] = 1'b0;
      waitc[served] = 0;
    end
  endtask

  initial begin
    int s, prev, old40, burst;
    int lock_exp [8] = '{-1, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    for (int m = 0; m < 2; m++) begin
      m_we[m] = 0; m_be[m] = 0; m_addr[m] = 0; m_wd[m] = 0; m_pc[m] = 0; waitc[m] = 0;
    end
    do_reset();
    mem_clear = 1'b0;

    // reset state: everything quiet
    chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
    chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
    cycle(s);

    // single read, ack one cycle after the request is seen
    set_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    cycle(s); chk("rd_lat_idle", 32'(s), 32'hFFFF_FFFF);
    cycle(s); chk("rd_lat_ack", 32'(s), 32'd0);

    // simultaneous write by m0 and read by m1 of the same word
    do_reset();
    set_txn(0, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 1'b0);
    set_txn(1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    cycle(s);
    cycle(s); chk("tie_first_m0", 32'(s), 32'd0);
    cycle(s); chk("then_m1", 32'(s), 32'd1);
    chk("mem_20", mem[8], 32'hDEADBEEF);

    // both saturating: strict alternation
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      for (int m = 0; m < 2; m++) if (!act[m]) begin rand_txn(m); m_lock[m] = 1'b0; end
      cycle(s);
      if (s >= 0 && prev >= 0) chk("alternate", 32'(s != prev), 32'd1);
      if (s >= 0) prev = s;
    end

    // owner drops its request while granted
    do_reset();
    set_txn(0, 1'b1, 4'hF, 32'h30, 32'h0BAD_F00D, 1'b0);
    cycle(s);
    act[0] = 1'b0;
    set_txn(1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
    cycle(s); chk("drop_no_xfer", 32'(s), 32'hFFFF_FFFF);
    cycle(s); chk("drop_regrant", 32'(s), 32'd1);
    chk("mem_30", mem[12], 32'd0);

    // reset in the middle of an m1 write
    do_reset();
    old40 = int'(mem[16]);
    set_txn(1, 1'b1, 4'hF, 32'h40, 32'h1234_5678, 1'b0);
    cycle(s);
    drive();
    #2;
    chk("pre_rst_we", 32'(bus.DMcurWE), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_ack", 32'(bus.m1_ack), 32'd0);
    chk("rst_we", 32'(bus.DMcurWE), 32'd0);
    chk("rst_adr", bus.DMAdr, 32'd0);
    chk("rst_dataw", bus.DMDataW, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    act[1] = 1'b0;
    owner = -1; last = 1'b1; lcnt = 0;
    chk("mem_40_kept", mem[16], 32'(old40));
    cycle(s); chk("rst_idle", 32'(s), 32'hFFFF_FFFF);

`ifdef DM_ARB_LOCK_EN
    // locked burst of 6 from m0 against a waiting m1
    do_reset();
    burst = 1;
    set_txn(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    set_txn(1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(s);
      chk("lock_seq", 32'(s), 32'(lock_exp[i]));
      if (s == 0 && burst < 6) begin
        set_txn(0, 1'b0, 4'h0, 32'(burst) << 2, 32'h0, 1'b1);
        burst++;
      end
    end
    act[0] = 1'b0;
    cycle(s);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) if (!act[m] && $urandom_range(0, 9) < 6) rand_txn(m);
      cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
